quad_decoder: RTL and testbench

//  Decodes a 2-phase quadrature input (a, b) into direction-tagged step pulses
//  and accumulates them in a WIDTH-bit up/down position count.
//  It is the input-side partner of the up/down counter: it turns an external

---
 rtl/qdec_pkg.sv | 20 ++
 rtl/qdec_sync.sv | 28 ++
 rtl/quad_decoder.sv | 122 ++++++++++++
 tb/tb_quad_decoder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/qdec_pkg.sv
// Shared types and the phase-transition decode for the quadrature decoder.
// Phases are packed as {a, b}.
package qdec_pkg;

    typedef enum logic [0:0] {PRIME, TRACK} qdec_state_t;

    typedef logic [1:0] phase_t;

    // Returns {valid, up}. valid=0 when nothing changed or both bits flipped.
    // For a single-bit change, up = prev[1] ^ cur[0]. This walks the
    // 00->01->11->10->00 cycle forward.
    function automatic logic [1:0] qdec_dir(phase_t prev, phase_t cur);
        logic valid;
        logic up;
        valid = ^(prev ^ cur);
        up    = prev[1] ^ cur[0];
        return {valid, valid & up};
    endfunction

endpackage

// File: rtl/qdec_sync.sv
// Multi-flop synchronizer for a single asynchronous input bit.
module qdec_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: turns synchronized a/b phase changes into step/ud pulses and a wrapping count.
// Define QDEC_ERR_EN to get a sticky err flag on illegal (two-bit) transitions; otherwise err stays 0.
module quad_decoder
    import qdec_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             en,
    input  logic             clr,
    output logic             step,
    output logic             ud,
    output logic [WIDTH-1:0] cont,
    output logic             err
);

    localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 1);

    logic        sa;
    logic        sb;
    phase_t      s;

    qdec_state_t state_q,     state_d;
    logic [CNT_W-1:0] prime_cnt_q, prime_cnt_d;
    phase_t      prev_q,      prev_d;
    logic        step_q,      step_d;
    logic        ud_q,        ud_d;
    logic [WIDTH-1:0] cont_q, cont_d;
    logic        err_q,       err_d;
    logic [1:0]  dir;

    qdec_sync #(.STAGES(SYNC_STAGES)) u_sync_a (
        .clk (clk),
        .rst (rst),
        .d   (a),
        .q   (sa)
    );

    qdec_sync #(.STAGES(SYNC_STAGES)) u_sync_b (
        .clk (clk),
        .rst (rst),
        .d   (b),
        .q   (sb)
    );

    assign s = {sa, sb};

    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        prev_d      = prev_q;
        step_d      = 1'b0;
        ud_d        = ud_q;
        cont_d      = cont_q;
        err_d       = err_q;
        dir         = qdec_dir(prev_q, s);

        unique case (state_q)
            // Hold off until the synchronizer reflects the real pins, so a nonzero
            // phase at reset release is not counted.
            PRIME: begin
                if (prime_cnt_q == CNT_W'(SYNC_STAGES)) begin
                    prev_d  = s;
                    state_d = TRACK;
                end else begin
                    prime_cnt_d = prime_cnt_q + CNT_W'(1);
                end
            end
            TRACK: begin
                prev_d = s;
                if (dir[1] && en) begin
                    step_d = 1'b1;
                    ud_d   = dir[0];
                    cont_d = dir[0] ? cont_q + WIDTH'(1) : cont_q - WIDTH'(1);
                end
`ifdef QDEC_ERR_EN
                if ((prev_q ^ s) == 2'b11) begin
                    err_d = 1'b1;
                end
`endif
            end
        endcase

        // Clear wins over a same-cycle decode; the transition is still consumed via prev.
        if (clr) begin
            cont_d = '0;
            step_d = 1'b0;
            ud_d   = ud_q;
            err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= PRIME;
            prime_cnt_q <= '0;
            prev_q      <= '0;
            step_q      <= 1'b0;
            ud_q        <= 1'b0;
            cont_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
            prev_q      <= prev_d;
            step_q      <= step_d;
            ud_q        <= ud_d;
            cont_q      <= cont_d;
            err_q       <= err_d;
        end
    end

    assign step = step_q;
    assign ud   = ud_q;
    assign cont = cont_q;
    assign err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder (WIDTH=8, SYNC_STAGES=2).
module tb_quad_decoder;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned SYNC  = 2;
`ifdef QDEC_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             a;
    logic             b;
    logic             en;
    logic             clr;
    logic             step;
    logic             ud;
    logic [WIDTH-1:0] cont;
    logic             err;

    int checks = 0;
    int errors = 0;

    quad_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .en   (en),
        .clr  (clr),
        .step (step),
        .ud   (ud),
        .cont (cont),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Change the pins, then check that step appears exactly SYNC+1 edges later and lasts one cycle.
    task automatic move(input logic na, input logic nb, input logic exp_step, input logic exp_ud,
                        input logic [WIDTH-1:0] exp_cont, input string tag);
        a = na;
        b = nb;
        repeat (SYNC) tick();
        check({tag, "_early"}, 32'(step), 32'(0));
        tick();
        check({tag, "_step"}, 32'(step), 32'(exp_step));
        check({tag, "_ud"}, 32'(ud), 32'(exp_ud));
        check({tag, "_cont"}, 32'(cont), 32'(exp_cont));
        tick();
        check({tag, "_late"}, 32'(step), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        a   = 1'b1;
        b   = 1'b1;
        en  = 1'b1;
        clr = 1'b0;
        repeat (2) tick();
        check("rst_step", 32'(step), 32'(0));
        check("rst_ud", 32'(ud), 32'(0));
        check("rst_cont", 32'(cont), 32'(0));
        check("rst_err", 32'(err), 32'(0));

        // Pins sitting at 11 through reset release must not produce a count.
        rst = 1'b1;
        for (int i = 0; i < int'(SYNC) + 3; i++) begin
            tick();
            check("prime_step", 32'(step), 32'(0));
        end
        check("prime_cont", 32'(cont), 32'(0));

        // Walk to 00 without counting.
        en = 1'b0;
        move(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "park1");
        move(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, "park2");
        en = 1'b1;

        move(1'b0, 1'b1, 1'b1, 1'b1, 8'h01, "up1");
        move(1'b1, 1'b1, 1'b1, 1'b1, 8'h02, "up2");
        move(1'b1, 1'b0, 1'b1, 1'b1, 8'h03, "up3");
        move(1'b0, 1'b0, 1'b1, 1'b1, 8'h04, "up4");

        move(1'b1, 1'b0, 1'b1, 1'b0, 8'h03, "dn1");
        move(1'b1, 1'b1, 1'b1, 1'b0, 8'h02, "dn2");
        move(1'b0, 1'b1, 1'b1, 1'b0, 8'h01, "dn3");
        move(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "dn4");
        move(1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, "dn5_wrap");
        move(1'b1, 1'b1, 1'b1, 1'b0, 8'hFE, "dn6");

        en = 1'b0;
        move(1'b1, 1'b0, 1'b0, 1'b0, 8'hFE, "dis1");
        move(1'b0, 1'b0, 1'b0, 1'b0, 8'hFE, "dis2");
        move(1'b0, 1'b1, 1'b0, 1'b0, 8'hFE, "dis3");
        en = 1'b1;
        move(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, "en_up");

        // clr lands on the same edge as the 11->10 up decode.
        a = 1'b1;
        b = 1'b0;
        repeat (SYNC) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_step", 32'(step), 32'(0));
        check("clr_cont", 32'(cont), 32'(0));
        check("clr_ud", 32'(ud), 32'(1));
        tick();
        check("clr_consumed", 32'(step), 32'(0));
        move(1'b0, 1'b0, 1'b1, 1'b1, 8'h01, "post_clr");

        // Illegal 00->11 jump.
        move(1'b1, 1'b1, 1'b0, 1'b1, 8'h01, "illegal");
        check("err_set", 32'(err), 32'(ERR_ON));
        tick();
        check("err_hold", 32'(err), 32'(ERR_ON));
        move(1'b1, 1'b0, 1'b1, 1'b1, 8'h02, "after_illegal");
        check("err_sticky", 32'(err), 32'(ERR_ON));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("err_clr", 32'(err), 32'(0));
        check("err_clr_cont", 32'(cont), 32'(0));

        // Asynchronous reset mid-cycle.
        move(1'b0, 1'b0, 1'b1, 1'b1, 8'h01, "pre_rst");
        #2;
        rst = 1'b0;
        #1;
        check("arst_cont", 32'(cont), 32'(0));
        check("arst_ud", 32'(ud), 32'(0));
        check("arst_step", 32'(step), 32'(0));
        check("arst_err", 32'(err), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
